// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART register bridge: framing bytes, response codes,
// FSM state encoding and the saturating error-count helper.
package uart_bridge_pkg;

    localparam logic [7:0] SYNC   = 8'h55;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_ADDR    = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_EXEC    = 3'd5;
    localparam logic [2:0] S_RD_WAIT = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_bridge_timeout.sv
// Inter-byte timeout: down-counter reloaded by clr, decremented while en,
// expire pulses when the terminal count is reached.
module uart_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 27_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && !clr && (cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART byte-stream to register-bus bridge: parses 0x55-framed read/write commands
// with XOR checksum, returns one response byte. UART_BRIDGE_TIMEOUT_EN adds an inter-byte timeout.
//
// state     | meaning
// IDLE      | waiting for sync byte 0x55
// CMD       | waiting for command byte
// ADDR      | waiting for address byte
// DATA      | waiting for write data byte
// CSUM      | waiting for checksum byte
// EXEC      | register strobe cycle
// RD_WAIT   | capturing read data
// RESP      | response byte offered on TX
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 27_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);

    logic [2:0] state;
    logic       is_wr;
    logic [7:0] csum;
    logic       timeout_exp;

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic in_parse;
    assign in_parse = (state == S_CMD) || (state == S_ADDR) ||
                      (state == S_DATA) || (state == S_CSUM);

    uart_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid || !in_parse),
        .en     (in_parse),
        .expire (timeout_exp)
    );
`else
    assign timeout_exp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            is_wr     <= 1'b0;
            csum      <= 8'h00;
            tx_data   <= 8'h00;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            err_count <= 8'h00;
        end else if (timeout_exp) begin
            state     <= S_IDLE;
            err_count <= sat_inc(err_count);
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC) state <= S_CMD;
                end
                S_CMD: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            is_wr <= (rx_data == CMD_WR);
                            csum  <= rx_data;
                            state <= S_ADDR;
                        end else begin
                            tx_data   <= NAK;
                            err_count <= sat_inc(err_count);
                            state     <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        reg_addr <= rx_data[ADDR_W-1:0];
                        csum     <= csum ^ rx_data;
                        state    <= is_wr ? S_DATA : S_CSUM;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        reg_wdata <= rx_data;
                        csum      <= csum ^ rx_data;
                        state     <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state <= S_EXEC;
                        end else begin
                            tx_data   <= NAK;
                            err_count <= sat_inc(err_count);
                            state     <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_wr) begin
                        tx_data <= ACK;
                        state   <= S_RESP;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    tx_data <= reg_rdata;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (tx_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Decoded from state so async reset clears them with no clock edge.
    assign tx_valid  = (state == S_RESP);
    assign reg_wr_en = (state == S_EXEC) && is_wr;
    assign reg_rd_en = (state == S_EXEC) && !is_wr;
    assign busy      = (state != S_IDLE);

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command decoder between `uart_top` and the Sobel pipeline's configuration registers. Consumes received UART bytes, parses fixed-format read/write frames with XOR checksum, and drives a simple single-cycle register bus. Returns one response byte per frame on the UART TX handshake. Lets the PC tune thresholds and modes, and read back status, at run time.

## Interface
- `ADDR_W`, default 8: register address width; must be 8, one address byte per frame.
- `TIMEOUT_CYCLES`, default 27_000: inter-byte timeout, 1 ms at 27 MHz. Used only when the timeout is compiled in.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte pending.
- `tx_ready` in 1: TX accepts the byte; transfer happens when `tx_valid && tx_ready`.
- `reg_wr_en` out 1: one-cycle write strobe.
- `reg_rd_en` out 1: one-cycle read strobe.
- `reg_addr` out 8: register address.
- `reg_wdata` out 8: write data.
- `reg_rdata` in 8: read data, valid the cycle after `reg_rd_en`.
- `busy` out 1: high in every state except IDLE.
- `err_count` out 8: count of bad frames, saturating at 255.

## Operation
- **Frame formats:**
  - Write: `0x55`, `0x01`, addr, data, csum, where csum = `0x01^addr^data`.
  - Read: `0x55`, `0x02`, addr, csum, where csum = `0x02^addr`.
- **States:** IDLE, CMD, ADDR, DATA, CSUM, EXEC, RD_WAIT, RESP.
- **IDLE:** on `rx_valid` with `0x55`, go to CMD. Any other byte is ignored silently and is not counted.
- **CMD:**
  - Latch the command. `0x01` or `0x02` goes to ADDR.
  - Any other value latches response NAK (`0x15`), increments `err_count`, and goes to RESP.
- **ADDR:** latch addr. Write goes to DATA; read goes to CSUM.
- **DATA:** latch data, go to CSUM.
- **CSUM:** compare with the running XOR.
  - Match goes to EXEC.
  - Mismatch latches NAK, increments `err_count`, and goes to RESP.
- **EXEC:**
  - Write: assert `reg_wr_en` for one cycle, latch ACK (`0x06`), go to RESP.
  - Read: assert `reg_rd_en` for one cycle, go to RD_WAIT.
- **RD_WAIT:** capture `reg_rdata` as the response byte, go to RESP.
- **RESP:** hold `tx_valid=1` with `tx_data` stable until `tx_ready` is seen, then go to IDLE.
- **Bytes while busy:** `rx_valid` in EXEC, RD_WAIT or RESP is dropped. It neither restarts parsing nor counts as an error.
- **Sync byte mid-frame:** `0x55` arriving in CMD, ADDR, DATA or CSUM is treated as ordinary data. There is no resync mid-frame except via the timeout.
- **Bus output stability:** `reg_addr` and `reg_wdata` hold their last latched values between frames.

## Timing
- **Reset values:** state IDLE; `tx_valid` 0, `tx_data` 0x00, `reg_wr_en` 0, `reg_rd_en` 0, `reg_addr` 0x00, `reg_wdata` 0x00, `busy` 0, `err_count` 0. All take effect immediately on `rst_n` low, with no clock needed.
- **Reset mid-frame:** the partial frame is discarded and the register bus sees no strobe. A `tx_valid` that was high drops immediately.
- **Write latency:** `reg_wr_en` is high the cycle after the clock edge that accepts the csum byte. `tx_valid` rises one cycle after `reg_wr_en`.
- **Read latency:** `reg_rd_en` is high at cycle T+1 after the csum byte's edge. `reg_rdata` is sampled at the edge ending T+2, and `tx_valid` is high from T+3.
- **Strobe shape:** strobes are exactly one cycle wide, and `reg_wr_en` and `reg_rd_en` are never both high.
- **TX handshake:**
  - `tx_valid` never drops before acceptance.
  - If `tx_ready` is already high when `tx_valid` rises, transfer completes that cycle and IDLE follows next cycle.
- **Error counter:** `err_count` saturates at 255; no wrap.

## Configuration
- **`UART_BRIDGE_TIMEOUT_EN` defined:** a counter resets on each accepted `rx_valid` in CMD, ADDR, DATA or CSUM.
  - When it reaches `TIMEOUT_CYCLES` in any of those states, return to IDLE with no response and increment `err_count`.
  - The counter is idle in all other states.
- **Not defined:** no counter logic. A partial frame waits indefinitely for its remaining bytes.

## Structure
- **Package `uart_bridge_pkg`:**
  - Constants SYNC=`0x55`, CMD_WR=`0x01`, CMD_RD=`0x02`, ACK=`0x06`, NAK=`0x15`.
  - The state encoding (3-bit) for the eight states.
- **Sub-module `uart_bridge_timeout`:** the `TIMEOUT_CYCLES` counter with clear/enable inputs and an expire pulse. It is instantiated only under `UART_BRIDGE_TIMEOUT_EN`.

## Test plan
- **Good write:** `55 01 10 A5 B4` -> one-cycle `reg_wr_en` with addr 0x10, wdata 0xA5; then `tx_data=06`, `err_count=0`.
- **Good read:** `55 02 20 22` with `reg_rdata=3C` -> one `reg_rd_en` at addr 0x20; `tx_data=3C` appears 3 cycles after the csum strobe.
- **Bad checksum:** `55 01 10 A5 00` -> no `reg_wr_en`; `tx_data=15`; `err_count=1`. Unknown command `55 07` -> `tx_data=15` immediately; `err_count=2`.
- **Backpressure:** hold `tx_ready=0` for 100 cycles during a response -> `tx_valid` and `tx_data` stay stable. Inject `55 01 ...` bytes during this window -> all dropped, no extra strobes.
- **Timeout** (macro defined, `TIMEOUT_CYCLES=50`): send `55 01` then idle 60 cycles -> back in IDLE, `busy=0`, `err_count` +1, no TX. The following full good write succeeds.
- **Async reset:** assert `rst_n` low after the ADDR byte -> all outputs at reset values without a clock edge. A subsequent good frame succeeds.
